// File: rtl/counts_display_driver.sv
// Binary-to-BCD double-dabble converter driving a multiplexed
// common-anode 7-segment display with leading-zero blanking.
module counts_display_driver #(
    parameter int width     = 8,
    parameter int digits    = 3,
    parameter int clk_freq  = 7_000_000,
    parameter int scan_freq = 1000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [width-1:0]      counts,
    output logic [digits-1:0]     an,
    output logic [6:0]            seg,
    output logic [4*digits-1:0]   bcd,
    output logic                  busy
);

    localparam int scan_div = clk_freq / scan_freq;
    localparam int bw       = 4 * digits;
    localparam int cnt_w    = $clog2(width + 1);
    localparam int pre_w    = $clog2(scan_div);
    localparam int dig_w    = (digits > 1) ? $clog2(digits) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t            state;
    logic [width-1:0]  shift_reg;
    logic [width-1:0]  latched;
    logic [width-1:0]  last_val;
    logic [bw-1:0]     scratch;
    logic [bw-1:0]     adjusted;
    logic [cnt_w-1:0]  bit_cnt;
    logic [pre_w-1:0]  prescale;
    logic [dig_w-1:0]  d;
    logic [digits-1:0] blank;
    logic              zero_run;
    logic [3:0]        nibble;
    logic [6:0]        pattern;

    always_comb begin
        adjusted = scratch;
        for (int i = 0; i < digits; i++) begin
            if (scratch[4*i +: 4] >= 4'd5)
                adjusted[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
        end
    end

    // A digit is blank when it and everything above it is zero.
    always_comb begin
        blank    = '0;
        zero_run = 1'b1;
        for (int i = digits - 1; i >= 0; i--) begin
            zero_run = zero_run & (bcd[4*i +: 4] == 4'd0);
            blank[i] = (i != 0) && zero_run;
        end
    end

    always_comb begin
        nibble = bcd[4*int'(d) +: 4];
        case (nibble)
            4'd0:    pattern = 7'b1000000;
            4'd1:    pattern = 7'b1111001;
            4'd2:    pattern = 7'b0100100;
            4'd3:    pattern = 7'b0110000;
            4'd4:    pattern = 7'b0011001;
            4'd5:    pattern = 7'b0010010;
            4'd6:    pattern = 7'b0000010;
            4'd7:    pattern = 7'b1111000;
            4'd8:    pattern = 7'b0000000;
            4'd9:    pattern = 7'b0010000;
            default: pattern = 7'b1111111;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            bcd       <= '0;
            last_val  <= '0;
            latched   <= '0;
            shift_reg <= '0;
            scratch   <= '0;
            bit_cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (counts != last_val) begin
                        latched   <= counts;
                        shift_reg <= counts;
                        scratch   <= '0;
                        bit_cnt   <= '0;
                        busy      <= 1'b1;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    {scratch, shift_reg} <= {adjusted, shift_reg} << 1;
                    bit_cnt <= bit_cnt + cnt_w'(1);
                    if (bit_cnt == cnt_w'(width - 1))
                        state <= DONE;
                end
                DONE: begin
                    bcd      <= scratch;
                    last_val <= latched;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prescale <= '0;
            d        <= '0;
            an       <= ~digits'(1);
            seg      <= 7'b1000000;
        end else begin
            if (prescale == pre_w'(scan_div - 1)) begin
                prescale <= '0;
                d <= (d == dig_w'(digits - 1)) ? '0 : d + dig_w'(1);
            end else begin
                prescale <= prescale + pre_w'(1);
            end
            an  <= ~(digits'(1) << d);
            seg <= blank[d] ? 7'b1111111 : pattern;
        end
    end

endmodule

// File: tb/tb_counts_display_driver.sv
// Directed and randomized checks of counts_display_driver against
// an arithmetic reference model (decimal digits, scan phase).
module tb_counts_display_driver;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] counts;
    logic [2:0] an;
    logic [6:0] seg;
    logic [11:0] bcd;
    logic       busy;

    int errors = 0;
    int checks = 0;
    int k = 0;
    int model_last = 0;
    int perm[256];

    logic [6:0] seg_tbl[10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };
    int p10[3] = '{1, 10, 100};

    counts_display_driver #(
        .width(8), .digits(3), .clk_freq(8), .scan_freq(2)
    ) dut (
        .clk(clk), .reset(reset), .counts(counts),
        .an(an), .seg(seg), .bcd(bcd), .busy(busy)
    );

    always #5 clk = ~clk;

    // Edges since the last reset edge; sets the expected scan phase.
    always @(posedge clk) begin
        if (reset) k <= 0;
        else       k <= k + 1;
    end

    function automatic logic [31:0] to_bcd(input int v);
        return ((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic convert(input int v);
        logic [31:0] old;
        old = to_bcd(model_last);
        @(negedge clk);
        counts = 8'(v);
        if (v == model_last) begin
            tick();
            tick();
            chk("busy_nochg", 32'(busy), 0);
            chk("bcd_nochg", 32'(bcd), old);
        end else begin
            for (int i = 0; i < 9; i++) begin
                tick();
                chk("busy_conv", 32'(busy), 1);
                chk("bcd_hold", 32'(bcd), old);
            end
            tick();
            chk("busy_end", 32'(busy), 0);
            chk("bcd_conv", 32'(bcd), to_bcd(v));
            model_last = v;
        end
    endtask

    task automatic scan_check(input int val, input int n);
        int dd;
        logic [6:0] es;
        for (int i = 0; i < n; i++) begin
            tick();
            dd = ((k - 1) / 4) % 3;
            if (dd > 0 && val < p10[dd]) es = 7'b1111111;
            else                         es = seg_tbl[(val / p10[dd]) % 10];
            chk("an_scan", 32'(an), 32'(3'b111 & ~(3'b001 << dd)));
            chk("seg_scan", 32'(seg), 32'(es));
        end
    endtask

    initial begin
        reset  = 1'b1;
        counts = 8'd0;
        repeat (3) tick();
        chk("rst_bcd", 32'(bcd), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_an", 32'(an), 32'(3'b110));
        chk("rst_seg", 32'(seg), 32'(7'b1000000));
        @(negedge clk);
        reset = 1'b0;
        tick();
        chk("rel_busy0", 32'(busy), 0);
        tick();
        chk("rel_busy1", 32'(busy), 0);

        convert(237);
        scan_check(237, 12);
        convert(7);
        scan_check(7, 12);
        convert(105);
        scan_check(105, 12);

        // counts changes three cycles into the shift phase
        @(negedge clk);
        counts = 8'd100;
        tick();
        chk("mid_busy_n", 32'(busy), 1);
        repeat (3) tick();
        @(negedge clk);
        counts = 8'd200;
        repeat (5) tick();
        chk("mid_busy_n8", 32'(busy), 1);
        tick();
        chk("mid_bcd100", 32'(bcd), 32'h100);
        chk("mid_busy_dn", 32'(busy), 0);
        tick();
        chk("mid_rerise", 32'(busy), 1);
        repeat (8) tick();
        chk("mid_bcd_hold", 32'(bcd), 32'h100);
        tick();
        chk("mid_bcd200", 32'(bcd), 32'h200);
        chk("mid_busy_dn2", 32'(busy), 0);
        model_last = 200;

        // reset lands on the fourth shift cycle
        @(negedge clk);
        counts = 8'd255;
        tick();
        chk("rm_busy", 32'(busy), 1);
        repeat (3) tick();
        @(negedge clk);
        reset = 1'b1;
        tick();
        chk("rm_bcd", 32'(bcd), 0);
        chk("rm_busy0", 32'(busy), 0);
        @(negedge clk);
        counts = 8'd0;
        tick();
        @(negedge clk);
        reset = 1'b0;
        model_last = 0;
        tick();
        chk("rm_idle_busy", 32'(busy), 0);
        chk("rm_idle_bcd", 32'(bcd), 0);
        convert(255);
        scan_check(255, 4);

        convert(0);
        scan_check(0, 12);

        for (int i = 0; i < 256; i++) perm[i] = i;
        for (int i = 255; i > 0; i--) begin
            int j, t;
            j = int'($urandom_range(i, 0));
            t = perm[i];
            perm[i] = perm[j];
            perm[j] = t;
        end
        for (int i = 0; i < 256; i++) begin
            convert(perm[i]);
            if (i % 32 == 0) scan_check(perm[i], 12);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
